// File: rtl/requant_sched_ctrl.sv
// Round-robin scheduler sharing one 2-stage requantize (int32 -> int8) datapath among N_LANES producers.
// Build option REQUANT_SAT_CNT_EN adds a saturating sat_count output counting clamped results.
module requant_sched_ctrl #(
  parameter int N_LANES    = 4,
  parameter int N_CHANNELS = 64,
  parameter int QMIN       = -128,
  parameter int QMAX       = 127,
  parameter int CH_W       = $clog2(N_CHANNELS),
  parameter int LANE_W     = $clog2(N_LANES)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_addr,
  input  logic [31:0]              cfg_mult,
  input  logic [5:0]               cfg_shift,
  input  logic                     cfg_zp_sel,
  input  logic                     flush,
  input  logic [N_LANES-1:0]       lane_valid,
  output logic [N_LANES-1:0]       lane_ready,
  input  logic [N_LANES*32-1:0]    lane_acc,
  input  logic [N_LANES*CH_W-1:0]  lane_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [LANE_W-1:0]        out_lane,
  output logic [CH_W-1:0]          out_ch,
`ifdef REQUANT_SAT_CNT_EN
  output logic [15:0]              sat_count,
`endif
  output logic                     busy
);

  logic [31:0] tbl_mult  [N_CHANNELS];
  logic [5:0]  tbl_shift [N_CHANNELS];
  logic        tbl_zp    [N_CHANNELS];

  logic [LANE_W-1:0] rr_ptr, win_lane, rr_next;
  logic              win_found, grant, s1_load, s2_load;
  logic [31:0]       win_acc, lk_mult;
  logic [CH_W-1:0]   win_ch;
  logic [5:0]        lk_shift;
  logic              lk_zp;

  logic                     s1_valid;
  logic signed [31:0]       s1_acc, s1_mult;
  logic [5:0]               s1_shift;
  logic                     s1_zp;
  logic [LANE_W-1:0]        s1_lane;
  logic [CH_W-1:0]          s1_ch;

  logic signed [63:0] prod, prod_rnd;
  logic signed [31:0] r_scaled, r_shifted, pre_clamp;
  logic [5:0]         neg_shift;
  logic [7:0]         res;
  logic               res_sat;

  assign s2_load = !out_valid || out_ready;
  assign s1_load = s2_load || !s1_valid;
  assign busy    = s1_valid | out_valid;

  // First valid lane at or after rr_ptr, searching modulo N_LANES.
  always_comb begin
    win_found = 1'b0;
    win_lane  = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (!win_found && lane_valid[(int'(rr_ptr) + k) % N_LANES]) begin
        win_found = 1'b1;
        win_lane  = LANE_W'((int'(rr_ptr) + k) % N_LANES);
      end
    end
  end

  assign grant      = win_found && s1_load && !flush;
  assign lane_ready = grant ? (N_LANES'(1) << win_lane) : '0;
  assign rr_next    = LANE_W'((int'(win_lane) + 1) % N_LANES);
  assign win_acc    = lane_acc[int'(win_lane)*32 +: 32];
  assign win_ch     = lane_ch[int'(win_lane)*CH_W +: CH_W];

  // Out-of-range channels read as an all-zero entry.
  always_comb begin
    lk_mult  = '0;
    lk_shift = '0;
    lk_zp    = 1'b0;
    if (int'(win_ch) < N_CHANNELS) begin
      lk_mult  = tbl_mult[win_ch];
      lk_shift = tbl_shift[win_ch];
      lk_zp    = tbl_zp[win_ch];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        tbl_mult[i]  <= '0;
        tbl_shift[i] <= '0;
        tbl_zp[i]    <= 1'b0;
      end
    end else if (cfg_we && int'(cfg_addr) < N_CHANNELS) begin
      tbl_mult[cfg_addr]  <= cfg_mult;
      tbl_shift[cfg_addr] <= cfg_shift;
      tbl_zp[cfg_addr]    <= cfg_zp_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_acc   <= '0;
      s1_mult  <= '0;
      s1_shift <= '0;
      s1_zp    <= 1'b0;
      s1_lane  <= '0;
      s1_ch    <= '0;
    end else begin
      if (grant) rr_ptr <= rr_next;
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (s1_load) begin
        s1_valid <= grant;
        if (grant) begin
          s1_acc   <= win_acc;
          s1_mult  <= lk_mult;
          s1_shift <= lk_shift;
          s1_zp    <= lk_zp;
          s1_lane  <= win_lane;
          s1_ch    <= win_ch;
        end
      end
    end
  end

  // Q31 multiply with round-half-up, then signed shift, zero point and clamp.
  always_comb begin
    prod      = 64'(s1_acc) * 64'(s1_mult);
    prod_rnd  = prod + 64'sh4000_0000;
    r_scaled  = 32'(prod_rnd >>> 31);
    neg_shift = -s1_shift;
    if (!s1_shift[5] && s1_shift != 6'd0) r_shifted = r_scaled >>> s1_shift;
    else                                  r_shifted = r_scaled << neg_shift;
    pre_clamp = r_shifted + (s1_zp ? -32'sd1 : -32'sd128);
    res_sat   = 1'b1;
    if (pre_clamp < QMIN)      res = 8'(QMIN);
    else if (pre_clamp > QMAX) res = 8'(QMAX);
    else begin
      res     = 8'(pre_clamp);
      res_sat = 1'b0;
    end
  end

`ifdef REQUANT_SAT_CNT_EN
  logic out_sat;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      out_ch    <= '0;
`ifdef REQUANT_SAT_CNT_EN
      out_sat   <= 1'b0;
      sat_count <= '0;
`endif
    end else begin
`ifdef REQUANT_SAT_CNT_EN
      if (flush) sat_count <= '0;
      else if (out_valid && out_ready && out_sat && sat_count != 16'hFFFF)
        sat_count <= sat_count + 16'd1;
`endif
      if (flush) begin
        out_valid <= 1'b0;
      end else if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= res;
          out_lane <= s1_lane;
          out_ch   <= s1_ch;
`ifdef REQUANT_SAT_CNT_EN
          out_sat  <= res_sat;
`endif
        end
      end
    end
  end

`ifndef REQUANT_SAT_CNT_EN
  logic unused_sat;
  assign unused_sat = res_sat;
`endif

endmodule

// File: tb/tb_requant_sched_ctrl.sv
// Directed self-checking bench for requant_sched_ctrl (4 lanes, 64 channels).
module tb_requant_sched_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [31:0] cfg_mult;
  logic [5:0]  cfg_shift;
  logic        cfg_zp_sel;
  logic        flush;
  logic [3:0]  lane_valid, lane_ready;
  logic [127:0] lane_acc;
  logic [23:0] lane_ch;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_lane;
  logic [5:0]  out_ch;
  logic        busy;
`ifdef REQUANT_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  requant_sched_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mult(cfg_mult),
    .cfg_shift(cfg_shift), .cfg_zp_sel(cfg_zp_sel), .flush(flush), .lane_valid(lane_valid),
    .lane_ready(lane_ready), .lane_acc(lane_acc), .lane_ch(lane_ch), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane), .out_ch(out_ch),
`ifdef REQUANT_SAT_CNT_EN
    .sat_count(sat_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [31:0] acc, input logic [5:0] ch);
    lane_acc[i*32 +: 32] = acc;
    lane_ch[i*6 +: 6]    = ch;
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [31:0] m, input logic [5:0] s, input logic z);
    cfg_we = 1'b1; cfg_addr = a; cfg_mult = m; cfg_shift = s; cfg_zp_sel = z;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_mult = '0; cfg_shift = '0; cfg_zp_sel = 1'b0;
    flush = 1'b0; lane_valid = '0; lane_acc = '0; lane_ch = '0; out_ready = 1'b1;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic run_one(input int lane, input logic [31:0] acc, input logic [5:0] ch);
    set_lane(lane, acc, ch);
    lane_valid = 4'b0001 << lane;
    cyc();
    lane_valid = '0;
    cyc();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'd0) begin n_bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    n_cmp++; if (out_lane !== 2'd0) begin n_bad++; $display("FAIL reset_out_lane: got %0d want 0", out_lane); end
    n_cmp++; if (out_ch !== 6'd0) begin n_bad++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (lane_ready !== 4'b0) begin n_bad++; $display("FAIL reset_lane_ready: got %b want 0000", lane_ready); end
  endtask

  task automatic test_basic();
    cfg_write(6'd3, 32'h4000_0000, 6'd1, 1'b0);
    out_ready = 1'b1;
    set_lane(0, 32'd200, 6'd3);
    lane_valid = 4'b0001;
    #1;
    n_cmp++; if (lane_ready !== 4'b0001) begin n_bad++; $display("FAIL basic_grant: got %b want 0001", lane_ready); end
    cyc();
    lane_valid = '0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_latency_early: out_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    cyc();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'(-78)) begin n_bad++; $display("FAIL basic_data: got %0d want -78", $signed(out_data)); end
    n_cmp++; if (out_lane !== 2'd0) begin n_bad++; $display("FAIL basic_lane: got %0d want 0", out_lane); end
    n_cmp++; if (out_ch !== 6'd3) begin n_bad++; $display("FAIL basic_ch: got %0d want 3", out_ch); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_cfg_same_cycle();
    cfg_write(6'd5, 32'h4000_0000, 6'h3E, 1'b1);
    set_lane(1, 32'd10, 6'd5);
    lane_valid = 4'b0010;
    cfg_we = 1'b1; cfg_addr = 6'd5; cfg_mult = 32'h7FFF_FFFF; cfg_shift = 6'd0; cfg_zp_sel = 1'b0;
    #1;
    n_cmp++; if (lane_ready !== 4'b0010) begin n_bad++; $display("FAIL cfg_grant: got %b want 0010", lane_ready); end
    cyc();
    cfg_we = 1'b0;
    lane_valid = '0;
    cyc();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL cfg_old_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'd19) begin n_bad++; $display("FAIL cfg_old_data: got %0d want 19", $signed(out_data)); end
    n_cmp++; if (out_lane !== 2'd1) begin n_bad++; $display("FAIL cfg_old_lane: got %0d want 1", out_lane); end
    n_cmp++; if (out_ch !== 6'd5) begin n_bad++; $display("FAIL cfg_old_ch: got %0d want 5", out_ch); end
    run_one(1, 32'd10, 6'd5);
    n_cmp++; if (out_data !== 8'(-118)) begin n_bad++; $display("FAIL cfg_new_data: got %0d want -118", $signed(out_data)); end
    cyc();
  endtask

  task automatic test_round_robin();
    int exp_d;
    apply_reset();
    for (int i = 0; i < 4; i++) cfg_write(6'(8 + i), 32'h4000_0000, 6'd0, 1'b0);
    for (int i = 0; i < 4; i++) set_lane(i, 32'(20 * (i + 1)), 6'(8 + i));
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      lane_valid = (c < 6) ? 4'hF : 4'h0;
      #1;
      if (c < 6) begin
        n_cmp++;
        if (lane_ready !== (4'b0001 << (c % 4))) begin
          n_bad++; $display("FAIL rr_grant c=%0d: got %b want lane %0d", c, lane_ready, c % 4);
        end
      end
      if (c >= 2) begin
        exp_d = 10 * ((c - 2) % 4 + 1) - 128;
        n_cmp++;
        if (out_valid !== 1'b1 || out_lane !== 2'((c - 2) % 4) || out_data !== 8'(exp_d) || out_ch !== 6'(8 + (c - 2) % 4)) begin
          n_bad++;
          $display("FAIL rr_out c=%0d: got v=%b lane=%0d data=%0d ch=%0d want v=1 lane=%0d data=%0d ch=%0d",
                   c, out_valid, out_lane, $signed(out_data), out_ch, (c - 2) % 4, exp_d, 8 + (c - 2) % 4);
        end
      end
      cyc();
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_ready [9] = '{4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h4, 4'h8};
    logic [3:0] want;
    int q[$];
    int n_out = 0;
    int lane_exp;
    logic [7:0] held;
    for (int c = 0; c < 20; c++) begin
      lane_valid = (c < 9) ? 4'hF : 4'h0;
      out_ready  = (c >= 3 && c < 6) ? 1'b0 : 1'b1;
      #1;
      want = (c < 9) ? exp_ready[c] : 4'h0;
      n_cmp++;
      if (lane_ready !== want) begin n_bad++; $display("FAIL stall_ready c=%0d: got %b want %b", c, lane_ready, want); end
      for (int i = 0; i < 4; i++) if (lane_ready[i] && lane_valid[i]) q.push_back(i);
      if (c == 3) held = out_data;
      if (c == 4 || c == 5) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_bad++; $display("FAIL stall_hold c=%0d: got v=%b data=%0d want v=1 data=%0d", c, out_valid, $signed(out_data), $signed(held));
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL stall_dup: got lane %0d want no output", out_lane);
        end else begin
          lane_exp = q.pop_front();
          if (out_lane !== 2'(lane_exp) || out_data !== 8'(10 * (lane_exp + 1) - 128)) begin
            n_bad++; $display("FAIL stall_order: got lane=%0d data=%0d want lane=%0d data=%0d",
                              out_lane, $signed(out_data), lane_exp, 10 * (lane_exp + 1) - 128);
          end
        end
      end
      cyc();
    end
    n_cmp++; if (n_out != 6) begin n_bad++; $display("FAIL stall_count: got %0d outputs want 6", n_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_saturation();
    cfg_write(6'd20, 32'h7FFF_FFFF, 6'd0, 1'b0);
    out_ready = 1'b1;
    run_one(0, 32'h7FFF_FFFF, 6'd20);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'd127) begin n_bad++; $display("FAIL sat_high: got v=%b data=%0d want v=1 data=127", out_valid, $signed(out_data)); end
    run_one(0, 32'(-1000000), 6'd20);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(-128)) begin n_bad++; $display("FAIL sat_low: got v=%b data=%0d want v=1 data=-128", out_valid, $signed(out_data)); end
    cyc();
`ifdef REQUANT_SAT_CNT_EN
    n_cmp++; if (sat_count !== 16'd2) begin n_bad++; $display("FAIL sat_count: got %0d want 2", sat_count); end
`endif
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) set_lane(i, 32'(20 * (i + 1)), 6'(8 + i));
    out_ready = 1'b1;
    lane_valid = 4'hF;
    #1;
    n_cmp++; if (lane_ready !== 4'b0010) begin n_bad++; $display("FAIL flush_pre0: got %b want 0010", lane_ready); end
    cyc();
    n_cmp++; if (lane_ready !== 4'b0100) begin n_bad++; $display("FAIL flush_pre1: got %b want 0100", lane_ready); end
    cyc();
    flush = 1'b1;
    #1;
    n_cmp++; if (lane_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_ready: got %b want 0000", lane_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before: got %b want 1", busy); end
    cyc();
    flush = 1'b0;
    lane_valid = '0;
    #1;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_clear: got busy=%b v=%b want 0 0", busy, out_valid); end
`ifdef REQUANT_SAT_CNT_EN
    n_cmp++; if (sat_count !== 16'd0) begin n_bad++; $display("FAIL flush_sat_count: got %0d want 0", sat_count); end
`endif
    lane_valid = 4'hF;
    #1;
    n_cmp++; if (lane_ready !== 4'b1000) begin n_bad++; $display("FAIL flush_rr_kept: got %b want 1000", lane_ready); end
    cyc();
    lane_valid = '0;
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_lane !== 2'd3 || out_data !== 8'(-88)) begin
      n_bad++; $display("FAIL flush_after: got v=%b lane=%0d data=%0d want v=1 lane=3 data=-88", out_valid, out_lane, $signed(out_data));
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    lane_valid = 4'hF;
    cyc(); cyc();
    n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_setup: got v=%b busy=%b want 1 1", out_valid, busy); end
    lane_valid = '0;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'd0) begin
      n_bad++; $display("FAIL rst_mid_async: got v=%b busy=%b data=%0d want 0 0 0", out_valid, busy, out_data);
    end
    cyc();
    reset_n = 1'b1;
    out_ready = 1'b1;
    lane_valid = 4'hF;
    #1;
    n_cmp++; if (lane_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_mid_rr: got %b want 0001", lane_ready); end
    cyc();
    lane_valid = '0;
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(-128) || out_ch !== 6'd8) begin
      n_bad++; $display("FAIL rst_mid_tbl: got v=%b data=%0d ch=%0d want v=1 data=-128 ch=8", out_valid, $signed(out_data), out_ch);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_same_cycle();
    test_round_robin();
    test_stall();
    test_saturation();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
